// File: rtl/systolic_data_setup.sv
// Skews each unified-buffer activation vector diagonally onto the systolic
// array's left edge: row r sees its element r cycles after row 0.
module systolic_data_setup #(
  parameter int unsigned ROWS   = 32,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   unified_buffer_read_en_i,
  input  logic [ROWS*DATA_W-1:0] unified_buffer_data_i,
  input  logic                   flush_i,
  output logic [ROWS*DATA_W-1:0] row_data_o,
  output logic [ROWS-1:0]        row_valid_o,
  output logic                   busy_o,
  output logic                   drain_done_o
);

  localparam int unsigned CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;
  logic [RD_LAT-1:0] rd_pipe;
  logic [RD_LAT:0]   rd_ext;
  logic              cap;
  logic              cap_next;

  // rd_ext[k] is the strobe delayed by k cycles; cap_next is what cap will be next cycle.
  assign rd_ext   = {rd_pipe, unified_buffer_read_en_i};
  assign cap      = rd_ext[RD_LAT];
  assign cap_next = rd_ext[RD_LAT-1];

  // Strobe delay line; a flush drops queued strobes but keeps the one issued this cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_pipe <= '0;
    end else if (flush_i) begin
      rd_pipe <= RD_LAT'(unified_buffer_read_en_i);
    end else begin
      rd_pipe <= rd_ext[RD_LAT-1:0];
    end
  end

  // Status FSM runs one cycle ahead on cap_next so busy/drain_done come out registered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      drain_cnt    <= '0;
      busy_o       <= 1'b0;
      drain_done_o <= 1'b0;
    end else begin
      drain_done_o <= 1'b0;
      if (flush_i) begin
        state     <= IDLE;
        drain_cnt <= '0;
        busy_o    <= 1'b0;
      end else if (cap_next) begin
        state  <= ACTIVE;
        busy_o <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            // Only reachable with cap high right after a flush: that vector still drains.
            if (cap) begin
              state        <= DRAIN;
              drain_cnt    <= CNT_LOAD;
              busy_o       <= 1'b1;
              drain_done_o <= (CNT_LOAD == '0);
            end
          end
          ACTIVE: begin
            state        <= DRAIN;
            drain_cnt    <= CNT_LOAD;
            busy_o       <= 1'b1;
            drain_done_o <= (CNT_LOAD == '0);
          end
          DRAIN: begin
            if (drain_cnt == '0) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              drain_cnt    <= drain_cnt - CNT_W'(1);
              drain_done_o <= (drain_cnt == CNT_W'(1));
            end
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

  // Row r is an (r+1)-deep chain; empty slots carry zero data.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [r:0][DATA_W-1:0] d_q;
    logic [r:0]             v_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        d_q <= '0;
        v_q <= '0;
      end else if (flush_i) begin
        d_q <= '0;
        v_q <= '0;
      end else begin
        d_q[0] <= cap ? unified_buffer_data_i[r*DATA_W +: DATA_W] : '0;
        v_q[0] <= cap;
        for (int j = 1; j <= r; j++) begin
          d_q[j] <= d_q[j-1];
          v_q[j] <= v_q[j-1];
        end
      end
    end

    assign row_data_o[r*DATA_W +: DATA_W] = d_q[r];
    assign row_valid_o[r]                 = v_q[r];
  end

endmodule

// File: tb/tb_systolic_data_setup.sv
// Bench for systolic_data_setup: two instances (RD_LAT 1 and 3) checked every
// cycle against a strobe/flush history model, plus literal timing checks.
module tb_systolic_data_setup;

  localparam int ROWS = 32;
  localparam int DW   = 8;
  localparam int VW   = ROWS * DW;
  localparam int NC   = 2048;
  localparam int MAXS = 512;

  logic          clk;
  logic          rst_n;
  logic          en_in   [2];
  logic          fl_in   [2];
  logic [VW-1:0] dat_in  [2];
  logic [VW-1:0] rd_out  [2];
  logic [ROWS-1:0] rv_out [2];
  logic          busy_out [2];
  logic          done_out [2];

  int cyc;
  int n_tests;
  int n_fail;

  bit            en_h   [2][NC];
  bit            fl_h   [2][NC];
  bit            inrst  [NC];
  logic [VW-1:0] dat_h  [2][NC];
  logic [VW-1:0] obs_rd [2][NC];
  logic [ROWS-1:0] obs_rv [2][NC];
  bit            obs_busy [2][NC];
  bit            obs_done [2][NC];

  bit            s_en  [2][MAXS];
  bit            s_fl  [2][MAXS];
  logic [VW-1:0] s_dat [2][MAXS];

  systolic_data_setup #(.ROWS(ROWS), .DATA_W(DW), .RD_LAT(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n),
    .unified_buffer_read_en_i(en_in[0]), .unified_buffer_data_i(dat_in[0]),
    .flush_i(fl_in[0]), .row_data_o(rd_out[0]), .row_valid_o(rv_out[0]),
    .busy_o(busy_out[0]), .drain_done_o(done_out[0])
  );

  systolic_data_setup #(.ROWS(ROWS), .DATA_W(DW), .RD_LAT(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .unified_buffer_read_en_i(en_in[1]), .unified_buffer_data_i(dat_in[1]),
    .flush_i(fl_in[1]), .row_data_o(rd_out[1]), .row_valid_o(rv_out[1]),
    .busy_o(busy_out[1]), .drain_done_o(done_out[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model over recorded history ----------------
  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // No flush (or reset) in cycles a..b inclusive.
  function automatic bit clean(input int i, input int a, input int b);
    for (int f = a; f <= b; f++)
      if (f >= 0 && fl_h[i][f]) return 1'b0;
    return 1'b1;
  endfunction

  // A valid vector is captured in cycle c.
  function automatic bit cap_ok(input int i, input int c);
    int s;
    s = c - lat_of(i);
    if (s < 0) return 1'b0;
    if (!en_h[i][s]) return 1'b0;
    return clean(i, s + 1, c - 1);
  endfunction

  function automatic bit vld_m(input int i, input int t, input int r);
    int c;
    c = t - 1 - r;
    if (c < 0 || inrst[t]) return 1'b0;
    return cap_ok(i, c) && clean(i, c, t - 1);
  endfunction

  function automatic logic [VW-1:0] rows_m(input int i, input int t);
    logic [VW-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      if (vld_m(i, t, r)) v[r*DW +: DW] = dat_h[i][t-1-r][r*DW +: DW];
    return v;
  endfunction

  function automatic logic [ROWS-1:0] valid_m(input int i, input int t);
    logic [ROWS-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++) v[r] = vld_m(i, t, r);
    return v;
  endfunction

  // Busy from capture until that vector leaves the last row; cleared by flush.
  function automatic bit busy_m(input int i, input int t);
    if (t < 1 || inrst[t] || fl_h[i][t-1]) return 1'b0;
    for (int c = t - ROWS; c <= t; c++)
      if (c >= 0 && cap_ok(i, c) && clean(i, c, t - 1)) return 1'b1;
    return 1'b0;
  endfunction

  // Drain completes when the last row holds the newest vector and nothing followed it.
  function automatic bit done_m(input int i, input int t);
    if (!vld_m(i, t, ROWS - 1)) return 1'b0;
    for (int c = t - ROWS + 1; c <= t; c++)
      if (cap_ok(i, c)) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cyc < NC) begin
      inrst[cyc] = !rst_n;
      for (int i = 0; i < 2; i++) begin
        en_h[i][cyc]  = en_in[i] && rst_n;
        fl_h[i][cyc]  = fl_in[i] || !rst_n;
        dat_h[i][cyc] = dat_in[i];
        obs_rd[i][cyc]   = rd_out[i];
        obs_rv[i][cyc]   = rv_out[i];
        obs_busy[i][cyc] = busy_out[i];
        obs_done[i][cyc] = done_out[i];
        chk($sformatf("row_data[u%0d]@%0d", i, cyc), rd_out[i], rows_m(i, cyc));
        chk($sformatf("row_valid[u%0d]@%0d", i, cyc), VW'(rv_out[i]), VW'(valid_m(i, cyc)));
        chk($sformatf("busy[u%0d]@%0d", i, cyc), VW'(busy_out[i]), VW'(busy_m(i, cyc)));
        chk($sformatf("drain_done[u%0d]@%0d", i, cyc), VW'(done_out[i]), VW'(done_m(i, cyc)));
        if (!busy_out[i])
          chk($sformatf("idle_no_valid[u%0d]@%0d", i, cyc), VW'(rv_out[i]), '0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int w = 0; w < VW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [VW-1:0] vec_pat(input int k, input int off);
    logic [VW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = DW'(k + r + off);
    return v;
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < MAXS; k++) begin
        s_en[i][k]  = 1'b0;
        s_fl[i][k]  = 1'b0;
        s_dat[i][k] = rand_vec();
      end
  endtask

  task automatic play(input int n, output int base);
    @(posedge clk); #1;
    base = cyc;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 2; i++) begin
        en_in[i]  = s_en[i][k];
        fl_in[i]  = s_fl[i][k];
        dat_in[i] = s_dat[i][k];
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      en_in[i]  = 1'b0;
      fl_in[i]  = 1'b0;
      dat_in[i] = rand_vec();
    end
  endtask

  function automatic logic [DW-1:0] obyte(input int i, input int t, input int r);
    return obs_rd[i][t][r*DW +: DW];
  endfunction

  function automatic int cnt_done(input int i, input int a, input int b);
    int n;
    n = 0;
    for (int t = a; t <= b; t++) n += int'(obs_done[i][t]);
    return n;
  endfunction

  task automatic scen_single(input string tag);
    int b;
    int nv;
    clear_sched();
    s_en[0][0]  = 1'b1;
    s_dat[0][1] = vec_pat(0, 1);
    play(40, b);
    chk({tag, "_model_row0_c2"}, VW'(vld_m(0, b + 2, 0)), VW'(1));
    chk({tag, "_model_done_c33"}, VW'(done_m(0, b + 33)), VW'(1));
    chk({tag, "_row0_valid_c1"}, VW'(obs_rv[0][b+1][0]), VW'(0));
    chk({tag, "_row0_valid_c2"}, VW'(obs_rv[0][b+2][0]), VW'(1));
    chk({tag, "_row0_data_c2"}, VW'(obyte(0, b + 2, 0)), VW'(8'h01));
    chk({tag, "_row31_valid_c33"}, VW'(obs_rv[0][b+33][31]), VW'(1));
    chk({tag, "_row31_data_c33"}, VW'(obyte(0, b + 33, 31)), VW'(8'h20));
    chk({tag, "_done_c33"}, VW'(obs_done[0][b+33]), VW'(1));
    chk({tag, "_done_count"}, VW'(cnt_done(0, b, b + 39)), VW'(1));
    chk({tag, "_busy_c0"}, VW'(obs_busy[0][b]), VW'(0));
    chk({tag, "_busy_c1"}, VW'(obs_busy[0][b+1]), VW'(1));
    chk({tag, "_busy_c33"}, VW'(obs_busy[0][b+33]), VW'(1));
    chk({tag, "_busy_c34"}, VW'(obs_busy[0][b+34]), VW'(0));
    nv = 0;
    for (int t = b; t < b + 40; t++) nv += $countones(obs_rv[0][t]);
    chk({tag, "_valid_bits_total"}, VW'(nv), VW'(ROWS));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b;
    int nv;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en_in[i]  = 1'b0;
      fl_in[i]  = 1'b0;
      dat_in[i] = '0;
    end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    chk("reset_row_valid", VW'(rv_out[0]), '0);
    chk("reset_row_data", rd_out[0], '0);
    chk("reset_busy", VW'(busy_out[0]), '0);
    chk("reset_done", VW'(done_out[0]), '0);
    repeat (2) @(posedge clk);

    scen_single("single");

    // Back-to-back burst of 40 vectors.
    clear_sched();
    for (int k = 0; k < 40; k++) begin
      s_en[0][k]    = 1'b1;
      s_dat[0][k+1] = vec_pat(k, 0);
    end
    play(78, b);
    chk("burst_row5_k10", VW'(obyte(0, b + 17, 5)), VW'(8'h0f));
    chk("burst_row31_k39", VW'(obyte(0, b + 72, 31)), VW'(8'h46));
    chk("burst_done_c72", VW'(obs_done[0][b+72]), VW'(1));
    chk("burst_done_count", VW'(cnt_done(0, b, b + 77)), VW'(1));
    nv = 0;
    for (int t = b + 2; t <= b + 41; t++) nv += int'(obs_rv[0][t][0]);
    chk("burst_row0_continuous", VW'(nv), VW'(40));

    // Gap shorter than the drain re-enters ACTIVE without a pulse.
    clear_sched();
    for (int k = 0; k < 4; k++) s_en[0][k] = 1'b1;
    s_en[0][14] = 1'b1;
    s_en[0][15] = 1'b1;
    play(52, b);
    chk("gap_done_c48", VW'(obs_done[0][b+48]), VW'(1));
    chk("gap_done_count", VW'(cnt_done(0, b, b + 51)), VW'(1));
    nv = 0;
    for (int t = b + 1; t <= b + 48; t++) nv += int'(obs_busy[0][t]);
    chk("gap_busy_held", VW'(nv), VW'(48));

    // RD_LAT=3 instance: only the data present three cycles after the strobe counts.
    clear_sched();
    s_en[1][5]  = 1'b1;
    s_dat[1][8] = vec_pat(0, 8'h40);
    play(45, b);
    chk("lat3_row0_valid_c8", VW'(obs_rv[1][b+8][0]), VW'(0));
    chk("lat3_row0_valid_c9", VW'(obs_rv[1][b+9][0]), VW'(1));
    chk("lat3_row0_data_c9", VW'(obyte(1, b + 9, 0)), VW'(8'h40));
    chk("lat3_row31_data_c40", VW'(obyte(1, b + 40, 31)), VW'(8'h5f));
    chk("lat3_done_c40", VW'(obs_done[1][b+40]), VW'(1));

    // Flush at cycle 10 of a 20-vector burst.
    clear_sched();
    for (int k = 0; k < 20; k++) begin
      s_en[0][k]    = 1'b1;
      s_dat[0][k+1] = vec_pat(k, 8'h80);
    end
    s_fl[0][10] = 1'b1;
    play(60, b);
    chk("flush_valid_c11", VW'(obs_rv[0][b+11]), '0);
    chk("flush_busy_c11", VW'(obs_busy[0][b+11]), VW'(0));
    chk("flush_done_c11", VW'(obs_done[0][b+11]), VW'(0));
    chk("flush_row0_data_c12", VW'(obyte(0, b + 12, 0)), VW'(8'h8a));
    chk("flush_busy_c12", VW'(obs_busy[0][b+12]), VW'(1));
    chk("flush_done_c52", VW'(obs_done[0][b+52]), VW'(1));
    chk("flush_done_count", VW'(cnt_done(0, b, b + 59)), VW'(1));

    // Randomized traffic and flushes on both instances.
    clear_sched();
    for (int k = 0; k < 400; k++)
      for (int i = 0; i < 2; i++) begin
        s_en[i][k] = (k >= 150 && k < 200) ? 1'b0 : ($urandom_range(0, 99) < 55);
        s_fl[i][k] = ($urandom_range(0, 99) < 3);
      end
    play(450, b);

    // Async reset in the middle of a stream.
    clear_sched();
    for (int k = 0; k < 8; k++) begin
      s_en[0][k] = 1'b1;
      s_en[1][k] = 1'b1;
    end
    play(8, b);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("async_rst_valid_u%0d", i), VW'(rv_out[i]), '0);
      chk($sformatf("async_rst_data_u%0d", i), rd_out[i], '0);
      chk($sformatf("async_rst_busy_u%0d", i), VW'(busy_out[i]), '0);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    scen_single("post_reset");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_data_setup.md
Name: systolic_data_setup

Overview:
- Sits directly downstream of the unified buffer read controller: consumes each ROWS-wide activation vector read from the unified buffer and skews it diagonally into the systolic array's left edge.
- Row r receives its element r cycles later than row 0.
- Tracks in-flight vectors and reports busy/drain completion to the top-level controller.

Parameters:
- ROWS, 32, systolic array height; also the vector width in elements (matches 32-row tiling).
- DATA_W, 8, bits per activation element.
- RD_LAT, 1, unified buffer read latency in cycles (read enable to data valid); legal range 1..4.

Ports:
- clk_i  input  1  clock; all state is on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- unified_buffer_read_en_i  input  1  read strobe issued to the unified buffer by its control unit.
- unified_buffer_data_i  input  ROWS*DATA_W  read data, valid RD_LAT cycles after the strobe; element r at bits [r*DATA_W +: DATA_W].
- flush_i  input  1  synchronous clear of all in-flight data (abort).
- row_data_o  output  ROWS*DATA_W  skewed data into array rows; element r drives row r.
- row_valid_o  output  ROWS  per-row valid.
- busy_o  output  1  high while any vector is in flight or being captured.
- drain_done_o  output  1  one-cycle pulse when the last in-flight element leaves row ROWS-1.

Behaviour:
- Reset (rst_i low, async):
  - row_data_o=0, row_valid_o=0, busy_o=0, drain_done_o=0.
  - Strobe delay pipeline cleared; FSM to IDLE; drain counter=0.
- Capture:
  - unified_buffer_read_en_i is delayed through an RD_LAT-deep shift register, giving cap.
  - When cap is high, unified_buffer_data_i is the valid vector for that cycle.
- Skew timing:
  - A vector captured at cycle t appears with element r on row_data_o[r] and row_valid_o[r]=1 at cycle t+1+r.
  - Row r is therefore a register chain of depth r+1 carrying data and valid.
  - Minimum latency from strobe to row 0 is RD_LAT+1 cycles.
- Slots where cap was low propagate valid=0 and data=0. Invalid rows must drive zero data so the array accumulates nothing.
- Back-to-back captures (cap high every cycle) stream without bubbles: full throughput of one vector per cycle.
- FSM, three states:
  - IDLE: busy_o=0. cap → ACTIVE.
  - ACTIVE: busy_o=1. A cycle with cap=0 → DRAIN, with drain counter loaded to ROWS-1.
  - DRAIN: busy_o=1; counter decrements each cycle.
    - cap=1 → ACTIVE (counter abandoned).
    - Counter==0 and cap=0 → IDLE, asserting drain_done_o for exactly that transition cycle.
    - That cycle is the one in which the last valid element is on row ROWS-1.
- Drain counter width: $clog2(ROWS); no wrap beyond ROWS-1.
- flush_i:
  - Next edge clears all delay chains, the strobe pipeline, row_valid_o and row_data_o.
  - FSM → IDLE; drain_done_o is not pulsed.
  - flush_i has priority over a simultaneous cap; the captured vector is discarded.
- Reset mid-stream: all partially skewed vectors are lost; no output glitch beyond the asynchronous clear.
- Invariant: busy_o=0 implies row_valid_o==0 (bench assertion).
- The block never back-pressures. The upstream controller must not strobe faster than one read per cycle; there is no other constraint.

Test Plan:
- Single vector, defaults (ROWS=32, DATA_W=8, RD_LAT=1):
  - Stimulus: strobe at cycle 0 with data element r = r+1.
  - Required: row 0 = 0x01 valid at cycle 2; row 31 = 0x20 valid at cycle 33; each row valid for exactly 1 cycle.
  - Required: drain_done_o pulses at cycle 33; busy_o high cycles 1..33.
- Burst of 40 back-to-back vectors, vector k element r = (k+r) mod 256:
  - Required: row r at cycle k+2+r shows (k+r) mod 256, with valid continuous; exactly one drain_done_o, at cycle 39+33=72.
- Gap re-entry:
  - Stimulus: vectors at cycles 0-3, idle 10 cycles, vectors at 14-15.
  - Required: no drain_done_o before the final drain; busy_o stays 1 throughout; drain_done_o at cycle 15+33=48.
- RD_LAT=3:
  - Stimulus: single strobe at cycle 5.
  - Required: row 0 valid at cycle 9, row 31 at cycle 40; data captured from input at cycle 8 only (input data at other cycles is ignored).
- flush_i at cycle 10 during a 20-vector burst (strobes from cycle 0):
  - Required: cycle 11: row_valid_o==0, busy_o=0, no drain_done_o.
  - Required: strobes at 10-19 remain; their vectors are captured from cycle 11 (cap at 10 is discarded), so valid outputs resume with fresh vectors only.
- Async reset asserted mid-cycle during streaming:
  - Required: outputs go to 0 immediately, before the next clock edge.
  - Required: after release, the first strobe behaves as in scenario 1.
